sma_window_accumulator: RTL and testbench
=========================================

Name: sma_window_accumulator

Overview:
- Sliding-window running-sum stage of the SMA pipeline.
- Holds the last 2^LOG2_WINDOW input samples in a circular buffer and keeps sum = sum + newest - oldest.
- Presents a registered window sum with a valid/ready handshake to the downstream power-of-2 divider, which turns it into the average.

Parameters:
DATA_WIDTH, 8, width of one unsigned input sample
LOG2_WINDOW, 2, log2 of window length; WINDOW = 2^LOG2_WINDOW (default 4)
SUM_WIDTH, DATA_WIDTH+LOG2_WINDOW, width of sum_out; derived, must not be overridden smaller
EMIT_DURING_FILL, 0, 1 = also emit partial sums while the window is filling

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of window, sum and output register
in_valid  input  1  in_data holds a sample
in_ready  output  1  stage can accept a sample this cycle
in_data  input  DATA_WIDTH  unsigned sample
sum_valid  output  1  sum_out holds a window sum
sum_ready  input  1  downstream divider accepts sum_out
sum_out  output  SUM_WIDTH  registered window sum, unsigned
window_full  output  1  WINDOW samples accepted since reset/clear
fill_count  output  LOG2_WINDOW+1  samples in window, saturates at WINDOW

Behaviour:
- Reset (rst_n low, asynchronous):
  - all buffer entries 0; wr_ptr 0; running sum 0.
  - sum_out 0, sum_valid 0, fill_count 0, window_full 0; state FILL.
  - Reset is legal mid-operation; any pending output is discarded.
- Handshakes:
  - Accept = in_valid & in_ready.
  - in_ready = !sum_valid | sum_ready. This is a single output register with pass-through readiness; there is no combinational path from in_valid to in_ready.
  - Output transfer = sum_valid & sum_ready.
  - While sum_valid=1 and sum_ready=0, sum_out and sum_valid hold stable.
- On accept:
  - buf[wr_ptr] <= in_data.
  - sum_next = sum + in_data - buf[wr_ptr]. Use the old entry; entries are 0 until first written, so no special case is needed during fill.
  - wr_ptr increments, wrapping WINDOW-1 -> 0.
  - fill_count increments until it reaches WINDOW.
- Arithmetic:
  - Unsigned; intermediate carried at SUM_WIDTH+1 bits.
  - Result always fits SUM_WIDTH, since the maximum is WINDOW*(2^DATA_WIDTH-1). No saturation is needed.
- States:
  - FILL: fill_count < WINDOW.
    - Accepted samples update the sum.
    - Output is produced only if EMIT_DURING_FILL=1.
    - The accept that makes fill_count = WINDOW emits the sum and moves to RUN.
  - RUN: every accept emits the new sum. Stays in RUN until reset or clear.
- Latency: sum_out/sum_valid are updated on the clock edge that accepts the sample, i.e. visible 1 cycle after the accept.
- Simultaneous accept and output transfer in the same cycle: the new sum replaces the old one and sum_valid stays 1. Full throughput is 1 sample/cycle.
- window_full = (state == RUN).
- clear (synchronous):
  - Has priority over a simultaneous accept; that sample is dropped.
  - Returns all state to reset values, including sum_valid = 0 (pending output discarded).
  - in_ready is 1 in the cycle after clear.

Test Plan:
- Defaults, sum_ready=1, feed 10,20,30,40 back-to-back -> no sum_valid for first three; sum_out=100, sum_valid=1 one cycle after 40 accepted; window_full=1, fill_count=4.
- Continue 50,60 -> sum_out=140 then 180 on consecutive cycles. This checks oldest-sample subtraction and pointer wrap.
- Feed 255 x6 -> sum_out=1020 (0x3FC, 10 bits), repeated with no overflow.
- In RUN, hold sum_ready=0 and drive in_valid=1 -> in_ready=0 after one output; sum_out frozen; no sample lost. Release -> sums resume in order.
- Feed 5,6, then assert clear together with in_valid (data 7) -> fill_count=0, sum_valid=0; then 1,1,1,1 -> sum_out=4. This confirms the 7 was dropped and old data flushed.
- EMIT_DURING_FILL=1, feed 3,4,5 -> outputs 3,7,12. Then assert rst_n=0 mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sma_window_accumulator.sv
// Sliding-window running sum: keeps the last 2^LOG2_WINDOW samples in a circular buffer and
// presents sum(newest..oldest) through a single valid/ready output register.
module sma_window_accumulator #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned LOG2_WINDOW      = 2,
  parameter int unsigned SUM_WIDTH        = DATA_WIDTH + LOG2_WINDOW,
  parameter bit          EMIT_DURING_FILL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [SUM_WIDTH-1:0]   sum_out,
  output logic                   window_full,
  output logic [LOG2_WINDOW:0]   fill_count
);

  localparam int unsigned Window = 2 ** LOG2_WINDOW;
  localparam logic [LOG2_WINDOW:0] FillMax = (LOG2_WINDOW + 1)'(Window);

  typedef enum logic {StFill, StRun} state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    win_q [Window];
  logic [DATA_WIDTH-1:0]    win_d [Window];
  logic [LOG2_WINDOW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [SUM_WIDTH-1:0]     sum_q, sum_d;
  logic [LOG2_WINDOW:0]     fill_q, fill_d;
  logic [SUM_WIDTH-1:0]     out_q, out_d;
  logic                     out_valid_q, out_valid_d;

  logic                     accept;
  logic                     emit;
  logic [SUM_WIDTH:0]       sum_ext;
  logic                     unused_carry;

  assign in_ready = !out_valid_q | sum_ready;
  assign accept   = in_valid & in_ready;

  // Unwritten entries are zero, so subtracting the old entry is also correct while filling.
  assign sum_ext = {1'b0, sum_q} + (SUM_WIDTH + 1)'(in_data)
                   - (SUM_WIDTH + 1)'(win_q[wr_ptr_q]);
  assign unused_carry = sum_ext[SUM_WIDTH];

  always_comb begin
    win_d       = win_q;
    wr_ptr_d    = wr_ptr_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
    emit        = 1'b0;

    if (clear) begin
      for (int i = 0; i < int'(Window); i++) begin
        win_d[i] = '0;
      end
      wr_ptr_d    = '0;
      sum_d       = '0;
      fill_d      = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      state_d     = StFill;
    end else begin
      if (out_valid_q && sum_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        win_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + LOG2_WINDOW'(1);
        sum_d           = sum_ext[SUM_WIDTH-1:0];
        if (fill_q != FillMax) begin
          fill_d = fill_q + (LOG2_WINDOW + 1)'(1);
        end
        case (state_q)
          StFill: begin
            if (fill_d == FillMax) begin
              emit    = 1'b1;
              state_d = StRun;
            end else begin
              emit = EMIT_DURING_FILL;
            end
          end
          StRun: emit = 1'b1;
        endcase
        // A new sum overwrites one being transferred this cycle, keeping valid high.
        if (emit) begin
          out_d       = sum_ext[SUM_WIDTH-1:0];
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Window); i++) begin
        win_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= StFill;
    end else begin
      win_q       <= win_d;
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

  assign sum_valid   = out_valid_q;
  assign sum_out     = out_q;
  assign window_full = (state_q == StRun);
  assign fill_count  = fill_q;

endmodule

// File: tb/tb_sma_window_accumulator.sv
// Bench for sma_window_accumulator: scoreboard of expected window sums for the default
// instance plus directed checks, and a second instance built with EMIT_DURING_FILL=1.
module tb_sma_window_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       sum_valid;
  logic       sum_ready = 1'b1;
  logic [9:0] sum_out;
  logic       window_full;
  logic [2:0] fill_count;

  logic       e_clear = 1'b0;
  logic       e_in_valid = 1'b0;
  logic       e_in_ready;
  logic [7:0] e_in_data = 8'd0;
  logic       e_sum_valid;
  logic       e_sum_ready = 1'b1;
  logic [9:0] e_sum_out;
  logic       e_window_full;
  logic [2:0] e_fill_count;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic        sb_en = 1'b0;

  int unsigned hist[$];
  int unsigned exp_q[$];
  int unsigned got_q[$];

  logic        o_ready, o_valid, o_full;
  int unsigned o_sum, o_fill;

  always #5 clk = ~clk;

  sma_window_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .sum_valid   (sum_valid),
    .sum_ready   (sum_ready),
    .sum_out     (sum_out),
    .window_full (window_full),
    .fill_count  (fill_count)
  );

  sma_window_accumulator #(
    .EMIT_DURING_FILL (1'b1)
  ) dut_e (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (e_clear),
    .in_valid    (e_in_valid),
    .in_ready    (e_in_ready),
    .in_data     (e_in_data),
    .sum_valid   (e_sum_valid),
    .sum_ready   (e_sum_ready),
    .sum_out     (e_sum_out),
    .window_full (e_window_full),
    .fill_count  (e_fill_count)
  );

  function automatic int unsigned win_sum();
    int unsigned s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  // Scoreboard: every output transfer must match the oldest outstanding expected sum.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (sum_valid && sum_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got sum %0d, required no output", sum_out);
        end else begin
          int unsigned e;
          e = exp_q.pop_front();
          got_q.push_back(32'(sum_out));
          if (32'(sum_out) !== e) $display("FAIL sb_sum: got %0d required %0d", sum_out, e);
          else n_pass++;
        end
      end else if (sum_ready && exp_q.size() != 0) begin
        n_checks++;
        $display("FAIL sb_missing: got sum_valid 0, required sum %0d", exp_q[0]);
      end
    end
  end

  // One cycle: drive inputs, sample outputs at negedge, update the model at the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    in_valid = v; in_data = d; sum_ready = r; clear = c;
    @(negedge clk);
    o_ready = in_ready; o_valid = sum_valid; o_sum = 32'(sum_out);
    o_full = window_full; o_fill = 32'(fill_count);
    @(posedge clk);
    if (c) begin
      hist.delete();
      exp_q.delete();
    end else if (v && o_ready) begin
      hist.push_back(32'(d));
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4) exp_q.push_back(win_sum());
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0d required 1", in_ready); else n_pass++;
    n_checks++; if (sum_valid !== 1'b0) $display("FAIL rst_sum_valid: got %0d required 0", sum_valid); else n_pass++;
    n_checks++; if (sum_out !== 10'd0) $display("FAIL rst_sum_out: got %0d required 0", sum_out); else n_pass++;
    n_checks++; if (fill_count !== 3'd0) $display("FAIL rst_fill: got %0d required 0", fill_count); else n_pass++;
    n_checks++; if (window_full !== 1'b0) $display("FAIL rst_full: got %0d required 0", window_full); else n_pass++;
    n_checks++; if (e_sum_valid !== 1'b0) $display("FAIL rst_e_valid: got %0d required 0", e_sum_valid); else n_pass++;
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    sb_en = 1'b1;
  endtask

  task automatic test_fill();
    logic [7:0] vals[4];
    vals = '{8'd10, 8'd20, 8'd30, 8'd40};
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b1, 1'b0);
      n_checks++; if (o_valid !== 1'b0) $display("FAIL fill_no_valid[%0d]: got %0d required 0", i, o_valid); else n_pass++;
      n_checks++; if (o_fill !== 32'(i)) $display("FAIL fill_count[%0d]: got %0d required %0d", i, o_fill, i); else n_pass++;
    end
    step(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL fill_first_valid: got %0d required 1", o_valid); else n_pass++;
    n_checks++; if (o_sum !== 100) $display("FAIL fill_first_sum: got %0d required 100", o_sum); else n_pass++;
    n_checks++; if (o_full !== 1'b1) $display("FAIL fill_full: got %0d required 1", o_full); else n_pass++;
    n_checks++; if (o_fill !== 4) $display("FAIL fill_count_max: got %0d required 4", o_fill); else n_pass++;
  endtask

  task automatic test_wrap();
    step(1'b1, 8'd50, 1'b1, 1'b0);
    step(1'b1, 8'd60, 1'b1, 1'b0);
    n_checks++; if (o_sum !== 140) $display("FAIL wrap_140: got %0d required 140", o_sum); else n_pass++;
    step(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++; if (o_sum !== 180) $display("FAIL wrap_180: got %0d required 180", o_sum); else n_pass++;
    n_checks++;
    if (got_q.size() != 3 || got_q[0] != 100 || got_q[1] != 140 || got_q[2] != 180)
      $display("FAIL wrap_sequence: got %0d outputs, required 100,140,180", got_q.size());
    else n_pass++;
  endtask

  task automatic test_max();
    int unsigned exp_sums[6];
    exp_sums = '{405, 620, 825, 1020, 1020, 1020};
    got_q.delete();
    repeat (6) step(1'b1, 8'd255, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++; if (got_q.size() != 6) $display("FAIL max_count: got %0d required 6", got_q.size()); else n_pass++;
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_sums[i]) $display("FAIL max_sum[%0d]: got %0d required %0d", i, got_q[i], exp_sums[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    n_checks++; if (o_ready !== 1'b0) $display("FAIL bp_ready_drop: got %0d required 0", o_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd2, 1'b0, 1'b0);
      n_checks++; if (o_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %0d required 0", i, o_ready); else n_pass++;
      n_checks++; if (o_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %0d required 1", i, o_valid); else n_pass++;
      n_checks++; if (o_sum !== 766) $display("FAIL bp_frozen[%0d]: got %0d required 766", i, o_sum); else n_pass++;
    end
    step(1'b1, 8'd2, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if (got_q.size() != 2 || got_q[0] != 766 || got_q[1] != 513)
      $display("FAIL bp_resume: got %0d outputs, required 766,513", got_q.size());
    else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_drained: got %0d pending required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_clear();
    got_q.delete();
    step(1'b1, 8'd5, 1'b1, 1'b0);
    step(1'b1, 8'd6, 1'b1, 1'b0);
    step(1'b1, 8'd7, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++; if (o_fill !== 0) $display("FAIL clr_fill: got %0d required 0", o_fill); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL clr_valid: got %0d required 0", o_valid); else n_pass++;
    n_checks++; if (o_ready !== 1'b1) $display("FAIL clr_ready: got %0d required 1", o_ready); else n_pass++;
    n_checks++; if (o_full !== 1'b0) $display("FAIL clr_full: got %0d required 0", o_full); else n_pass++;
    repeat (4) step(1'b1, 8'd1, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    n_checks++; if (o_valid !== 1'b1 || o_sum !== 4) $display("FAIL clr_refill: got valid %0d sum %0d required 1/4", o_valid, o_sum); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL clr_drained: got %0d pending required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_emit_fill();
    sb_en = 1'b0;
    e_in_valid = 1'b1; e_in_data = 8'd3;
    @(posedge clk); #1 e_in_data = 8'd4;
    @(negedge clk);
    n_checks++; if (e_sum_valid !== 1'b1 || e_sum_out !== 10'd3) $display("FAIL emit_3: got valid %0d sum %0d required 1/3", e_sum_valid, e_sum_out); else n_pass++;
    @(posedge clk); #1 e_in_data = 8'd5;
    @(negedge clk);
    n_checks++; if (e_sum_out !== 10'd7) $display("FAIL emit_7: got %0d required 7", e_sum_out); else n_pass++;
    @(posedge clk); #1 e_in_data = 8'd9;
    @(negedge clk);
    n_checks++; if (e_sum_out !== 10'd12) $display("FAIL emit_12: got %0d required 12", e_sum_out); else n_pass++;
    n_checks++; if (e_fill_count !== 3'd3 || e_window_full !== 1'b0) $display("FAIL emit_fill3: got fill %0d full %0d required 3/0", e_fill_count, e_window_full); else n_pass++;
    @(posedge clk); #2;
    n_checks++; if (e_sum_out !== 10'd21 || e_window_full !== 1'b1) $display("FAIL emit_21: got sum %0d full %0d required 21/1", e_sum_out, e_window_full); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (e_sum_out !== 10'd0) $display("FAIL async_rst_sum: got %0d required 0", e_sum_out); else n_pass++;
    n_checks++; if (e_sum_valid !== 1'b0) $display("FAIL async_rst_valid: got %0d required 0", e_sum_valid); else n_pass++;
    n_checks++; if (e_fill_count !== 3'd0 || e_window_full !== 1'b0) $display("FAIL async_rst_fill: got fill %0d full %0d required 0/0", e_fill_count, e_window_full); else n_pass++;
    e_in_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_max();
    test_backpressure();
    test_clear();
    test_emit_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
